fifo_read_unpacker: RTL and testbench
=====================================

# fifo_read_unpacker

Read-side consumer for the FIFO buffer. It pops PAR_READ words at a time from the FIFO's wide output port, which the FIFO indicates with `valid`. It then delivers them one NUM_BIT word per beat over a valid/ready stream to the downstream block, so the FIFO's wide read port is converted back to the single-word width used on the write side.

## Interface
- NUM_BIT, 4, width of one data word
- PAR_READ, 2, words popped per FIFO read; must be ≥ 2
- clk  in  1  rising-edge clock
- rst  in  1  asynchronous reset, active-low; block held in reset while rst = 0
- fifo_valid  in  1  FIFO `valid`: at least PAR_READ words are available
- fifo_dout  in  PAR_READ*NUM_BIT  FIFO wide read data; lane i = bits [(i+1)*NUM_BIT-1 : i*NUM_BIT]
- fifo_ren  out  1  pop strobe to the FIFO (its `inc_r`): one-cycle pulse, pops PAR_READ words
- flush  in  1  synchronous discard of the held words
- dout  out  NUM_BIT  current output word
- dout_valid  out  1  dout holds a valid word
- dout_ready  in  1  downstream accepts dout this cycle
- busy  out  1  holding register contains undelivered words

## Operation
- Two-state FSM with states IDLE and SHIFT. It has a PAR_READ*NUM_BIT holding register `hold` and a lane index `idx` of width $clog2(PAR_READ).
- fifo_ren is a Mealy output. It is 1 exactly when rst = 1, flush = 0, fifo_valid = 1, and one of these holds:
  - state = IDLE, or
  - state = SHIFT and idx = PAR_READ-1 and dout_ready = 1.
- Whenever fifo_ren = 1, the next edge loads hold ← fifo_dout, sets idx ← 0 and state ← SHIFT. fifo_dout is sampled in the same cycle that fifo_ren is asserted.
- IDLE with fifo_valid = 0: no change.
- In SHIFT:
  - dout = lane idx of hold; dout_valid = 1.
  - On an accept (dout_valid & dout_ready) with idx < PAR_READ-1: idx ← idx+1.
  - On an accept with idx = PAR_READ-1: reload if fifo_ren = 1, otherwise go to IDLE.
- Lane 0 (LSB word) is emitted first; lane PAR_READ-1 is emitted last.
- Without an accept, dout, dout_valid, idx and hold are all held stable. Valid must not drop and data must not change while waiting for ready.
- flush = 1 at an edge forces state ← IDLE and idx ← 0. hold is left as-is but is ignored. flush has priority over every other event, and fifo_ren is 0 in a flush cycle.
- busy = (state == SHIFT).
- In IDLE: dout_valid = 0 and dout = 0.

## Timing
- Reset (rst = 0, asynchronous) sets state = IDLE, idx = 0, hold = 0. While rst = 0: dout = 0, dout_valid = 0, busy = 0, fifo_ren = 0 regardless of fifo_valid.
- Deassertion of reset takes effect at the first clk edge with rst = 1.
- Latency: fifo_ren in cycle N gives dout_valid = 1 with lane 0 in cycle N+1.
- Throughput: with dout_ready = 1 and fifo_valid = 1 continuously, one word per cycle with no bubbles. fifo_ren pulses in the cycle lane PAR_READ-1 is accepted, and lane 0 of the next group appears the following cycle.
- At most one fifo_ren per PAR_READ accepted words. fifo_ren is never asserted while undelivered words remain in hold.
- If fifo_valid drops during SHIFT, the remaining held words still drain, then the FSM goes to IDLE. There are no further pops.
- Reset asserted mid-group discards the remaining words immediately. The FIFO pointers are reset by the same rst.

## Test plan
- Basic unpack (NUM_BIT = 4, PAR_READ = 2): fifo_dout = 8'hA5, fifo_valid pulsed for one cycle, dout_ready = 1.
  - Required: fifo_ren = 1 in cycle 0; dout = 4'h5 in cycle 1 and 4'hA in cycle 2, each with dout_valid = 1; IDLE with dout_valid = 0 in cycle 3.
- Back-to-back groups: fifo_valid = 1 steadily, fifo_dout = 8'h21 then 8'h43, dout_ready = 1.
  - Required: dout = 1, 2, 3, 4 in consecutive cycles; fifo_ren = 1 in cycles 0 and 2 only.
- Backpressure: hold dout_ready = 0 for 3 cycles after lane 0 appears.
  - Required: dout_valid stays 1, dout stays at lane 0 and fifo_ren stays 0 for all 3 cycles; lane 1 follows one cycle after dout_ready returns to 1.
- Flush mid-group: flush = 1 while lane 0 of 8'hA5 is presented.
  - Required: next cycle is IDLE with dout_valid = 0; 4'hA is never emitted; fifo_ren = 0 in the flush cycle even with fifo_valid = 1.
- Async reset: drive rst = 0 mid-cycle during SHIFT.
  - Required: dout_valid, busy and fifo_ren all drop to 0 immediately, before the next edge; after release, no output until fifo_valid = 1.
- Empty FIFO: fifo_valid = 0 for 10 cycles after reset.
  - Required: fifo_ren = 0, dout_valid = 0, busy = 0 throughout.

Source files
------------

// File: rtl/fifo_read_unpacker_if.sv
// fifo_read_unpacker_if: FIFO wide-read port plus single-word output stream.
interface fifo_read_unpacker_if #(
    parameter int NUM_BIT  = 4,
    parameter int PAR_READ = 2
);
    logic                        fifo_valid;
    logic [PAR_READ*NUM_BIT-1:0] fifo_dout;
    logic                        fifo_ren;
    logic                        flush;
    logic [NUM_BIT-1:0]          dout;
    logic                        dout_valid;
    logic                        dout_ready;
    logic                        busy;

    modport master (
        output fifo_valid, fifo_dout, flush, dout_ready,
        input  fifo_ren, dout, dout_valid, busy
    );

    modport slave (
        input  fifo_valid, fifo_dout, flush, dout_ready,
        output fifo_ren, dout, dout_valid, busy
    );
endinterface

// File: rtl/fifo_read_unpacker.sv
// fifo_read_unpacker: pops PAR_READ words from the FIFO and streams them out one per beat.
module fifo_read_unpacker #(
    parameter int NUM_BIT  = 4,
    parameter int PAR_READ = 2
) (
    input logic                 i_clk,
    input logic                 i_rst_n,
    fifo_read_unpacker_if.slave io
);
    localparam int IW = $clog2(PAR_READ);

    typedef enum logic {IDLE, SHIFT} state_t;

    state_t                            r_state;
    logic [IW-1:0]                     r_idx;
    logic [PAR_READ-1:0][NUM_BIT-1:0]  r_hold;
    logic                              w_last;
    logic                              w_accept;
    logic                              w_ren;

    assign w_last   = r_idx == IW'(PAR_READ - 1);
    assign w_accept = (r_state == SHIFT) && io.dout_ready;
    // reset gating keeps the pop strobe low while rst_n is held, independent of state
    assign w_ren    = i_rst_n && !io.flush && io.fifo_valid &&
                      ((r_state == IDLE) || (w_last && w_accept));

    assign io.fifo_ren   = w_ren;
    assign io.dout_valid = r_state == SHIFT;
    assign io.busy       = r_state == SHIFT;
    assign io.dout       = (r_state == SHIFT) ? r_hold[r_idx] : '0;

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_state <= IDLE;
            r_idx   <= '0;
            r_hold  <= '0;
        end else if (io.flush) begin
            r_state <= IDLE;
            r_idx   <= '0;
        end else if (w_ren) begin
            r_hold  <= io.fifo_dout;
            r_idx   <= '0;
            r_state <= SHIFT;
        end else if (w_accept) begin
            if (w_last) r_state <= IDLE;
            else        r_idx   <= r_idx + IW'(1);
        end
    end
endmodule

// File: tb/tb_fifo_read_unpacker.sv
// tb_fifo_read_unpacker: directed test-plan steps plus random traffic against a word-queue model.
module tb_fifo_read_unpacker;
    localparam int N = 4;
    localparam int P = 2;

    logic clk;
    logic rst_n;
    int   total;
    int   bad;
    int   nren;
    logic [N-1:0] mq[$];
    logic [N-1:0] got[$];

    fifo_read_unpacker_if #(.NUM_BIT(N), .PAR_READ(P)) bus ();

    fifo_read_unpacker #(.NUM_BIT(N), .PAR_READ(P)) dut (
        .i_clk   (clk),
        .i_rst_n (rst_n),
        .io      (bus)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s t=%0t got=%0h exp=%0h", tag, $time, obs, exp);
        end
    endtask

    // Model: the queue holds undelivered words; front is what must be on dout.
    task automatic tick();
        logic         ev;
        logic         er;
        logic [N-1:0] ed;
        @(negedge clk);
        ev = rst_n && mq.size() > 0;
        ed = ev ? mq[0] : '0;
        er = rst_n && !bus.flush && bus.fifo_valid &&
             (mq.size() == 0 || (mq.size() == 1 && bus.dout_ready));
        chk("dout_valid", 32'(bus.dout_valid), 32'(ev));
        chk("dout", 32'(bus.dout), 32'(ed));
        chk("fifo_ren", 32'(bus.fifo_ren), 32'(er));
        chk("busy", 32'(bus.busy), 32'(ev));
        if (bus.dout_valid && bus.dout_ready && !bus.flush) got.push_back(bus.dout);
        if (bus.fifo_ren) nren++;
        @(posedge clk);
        if (!rst_n || bus.flush) mq.delete();
        else if (er) begin
            mq.delete();
            for (int i = 0; i < P; i++) mq.push_back(bus.fifo_dout[i*N +: N]);
        end else if (ev && bus.dout_ready) void'(mq.pop_front());
        #1;
    endtask

    task automatic start();
        got.delete();
        nren = 0;
    endtask

    initial begin
        total = 0;
        bad   = 0;
        nren  = 0;
        rst_n = 1'b0;
        bus.fifo_valid = 1'b1;
        bus.fifo_dout  = 8'hA5;
        bus.flush      = 1'b0;
        bus.dout_ready = 1'b1;
        // reset holds everything low even with fifo_valid high
        tick();
        tick();
        bus.fifo_valid = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        // empty FIFO
        start();
        repeat (10) tick();
        chk("empty_ren", 32'(nren), 32'd0);
        // basic unpack
        start();
        bus.fifo_valid = 1'b1;
        bus.fifo_dout  = 8'hA5;
        tick();
        bus.fifo_valid = 1'b0;
        repeat (3) tick();
        chk("basic_cnt", 32'(got.size()), 32'd2);
        if (got.size() == 2) begin
            chk("basic_w0", 32'(got[0]), 32'h5);
            chk("basic_w1", 32'(got[1]), 32'hA);
        end
        chk("basic_ren", 32'(nren), 32'd1);
        // back-to-back groups
        start();
        bus.fifo_valid = 1'b1;
        bus.fifo_dout  = 8'h21;
        tick();
        tick();
        bus.fifo_dout = 8'h43;
        tick();
        bus.fifo_valid = 1'b0;
        repeat (2) tick();
        chk("b2b_cnt", 32'(got.size()), 32'd4);
        for (int i = 0; i < got.size() && i < 4; i++) chk("b2b_word", 32'(got[i]), 32'(i + 1));
        chk("b2b_ren", 32'(nren), 32'd2);
        // backpressure with fifo_valid still high
        start();
        bus.fifo_valid = 1'b1;
        bus.fifo_dout  = 8'hA5;
        tick();
        bus.dout_ready = 1'b0;
        repeat (3) tick();
        bus.dout_ready = 1'b1;
        tick();
        bus.fifo_valid = 1'b0;
        repeat (2) tick();
        chk("bp_cnt", 32'(got.size()), 32'd2);
        if (got.size() == 2) chk("bp_w1", 32'(got[1]), 32'hA);
        chk("bp_ren", 32'(nren), 32'd1);
        // flush mid-group
        start();
        bus.fifo_valid = 1'b1;
        tick();
        bus.flush = 1'b1;
        tick();
        bus.flush      = 1'b0;
        bus.fifo_valid = 1'b0;
        repeat (2) tick();
        chk("flush_cnt", 32'(got.size()), 32'd0);
        chk("flush_ren", 32'(nren), 32'd1);
        // asynchronous reset mid-group
        bus.fifo_valid = 1'b1;
        tick();
        #2 rst_n = 1'b0;
        #1;
        chk("arst_valid", 32'(bus.dout_valid), 32'd0);
        chk("arst_busy", 32'(bus.busy), 32'd0);
        chk("arst_ren", 32'(bus.fifo_ren), 32'd0);
        mq.delete();
        tick();
        rst_n = 1'b1;
        bus.fifo_valid = 1'b0;
        start();
        repeat (3) tick();
        chk("arst_idle", 32'(got.size()), 32'd0);
        // random traffic
        for (int c = 0; c < 400; c++) begin
            bus.fifo_valid = 1'($urandom_range(0, 3) != 0);
            bus.fifo_dout  = 8'($urandom);
            bus.dout_ready = 1'($urandom_range(0, 3) != 0);
            bus.flush      = 1'($urandom_range(0, 15) == 0);
            tick();
        end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
